// File: rtl/neuron_mac_stream_if.sv
// Stream interface for neuron_mac_stream: weight/pixel input beats, per-vector bias/ReLU
// control, and the result handshake with saturation flag.
interface neuron_mac_stream_if #(
  parameter int LANES = 16,
  parameter int WGT_W = 19,
  parameter int PIX_W = 10,
  parameter int ACC_W = 26
);
  logic                     Input_valid;
  logic                     Input_ready;
  logic [LANES*WGT_W-1:0]   Wgt_bus;
  logic [LANES*PIX_W-1:0]   Pix_bus;
  logic signed [ACC_W-1:0]  Bias;
  logic                     Relu_en;
  logic signed [ACC_W-1:0]  Out;
  logic                     Output_valid;
  logic                     Output_ready;
  logic                     Sat_flag;

  modport master (
    output Input_valid, Wgt_bus, Pix_bus, Bias, Relu_en, Output_ready,
    input  Input_ready, Out, Output_valid, Sat_flag
  );

  modport slave (
    input  Input_valid, Wgt_bus, Pix_bus, Bias, Relu_en, Output_ready,
    output Input_ready, Out, Output_valid, Sat_flag
  );
endinterface

// File: rtl/neuron_mac_stream.sv
// Streaming multiply-accumulate neuron: LANES weight*pixel products per beat, BEATS beats per
// vector, bias added once, optional ReLU, then saturation to ACC_W bits.
module neuron_mac_stream #(
  parameter int N_INPUTS = 64,
  parameter int LANES    = 16,
  parameter int WGT_W    = 19,
  parameter int PIX_W    = 10,
  parameter int ACC_W    = 26
) (
  input logic                clk,
  input logic                GlobalReset,
  neuron_mac_stream_if.slave bus
);

  localparam int BEATS = N_INPUTS / LANES;
  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int INT_W = WGT_W + PIX_W + 1 + $clog2(N_INPUTS) + 1;

  localparam logic signed [INT_W-1:0] MAX_V = (INT_W'(1) <<< (ACC_W - 1)) - INT_W'(1);
  localparam logic signed [INT_W-1:0] MIN_V = -(INT_W'(1) <<< (ACC_W - 1));

  if (N_INPUTS % LANES != 0) begin : g_cfg_err
    $error("neuron_mac_stream: N_INPUTS must be a multiple of LANES");
  end

  typedef enum logic [1:0] {IDLE, ACCUM, DRAIN, HOLD} state_t;

  state_t                  state, state_nxt;
  logic [CNT_W-1:0]        beat_cnt;
  logic                    ready_q;
  logic                    out_vld_q;
  logic                    accept;
  logic                    last_beat;
  logic                    first_beat;

  logic signed [INT_W-1:0] lane_sum_p0;
  logic signed [INT_W-1:0] sum_p1;
  logic                    vld_p1;
  logic                    first_p1;
  logic                    last_p1;
  logic signed [INT_W-1:0] acc_p2;
  logic                    done_p2;

  logic signed [ACC_W-1:0] bias_q;
  logic                    relu_q;
  logic [ACC_W:0]          result_p2;
  logic signed [ACC_W-1:0] out_q;
  logic                    sat_q;

  // Signed weight times pixel zero-extended by one bit, computed at the internal width.
  function automatic logic signed [INT_W-1:0] mul_lane(input logic signed [WGT_W-1:0] w,
                                                       input logic [PIX_W-1:0] p);
    logic signed [PIX_W:0]   ps;
    logic signed [INT_W-1:0] we;
    logic signed [INT_W-1:0] pe;
    ps = {1'b0, p};
    we = INT_W'(w);
    pe = INT_W'(ps);
    return we * pe;
  endfunction

  function automatic logic signed [INT_W-1:0] relu_fn(input logic signed [INT_W-1:0] v,
                                                      input logic en);
    if (en && (v < 0)) return '0;
    return v;
  endfunction

  // Returns {clamped, value}.
  function automatic logic [ACC_W:0] sat_fn(input logic signed [INT_W-1:0] v);
    if (v > MAX_V) return {1'b1, MAX_V[ACC_W-1:0]};
    if (v < MIN_V) return {1'b1, MIN_V[ACC_W-1:0]};
    return {1'b0, v[ACC_W-1:0]};
  endfunction

  assign accept     = bus.Input_valid & ready_q;
  assign last_beat  = (beat_cnt == CNT_W'(BEATS - 1));
  assign first_beat = (state == IDLE);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = last_beat ? DRAIN : ACCUM;
      ACCUM:   if (accept && last_beat) state_nxt = DRAIN;
      DRAIN:   if (done_p2) state_nxt = HOLD;
      HOLD:    if (bus.Output_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge GlobalReset) begin
    if (GlobalReset) begin
      state     <= IDLE;
      ready_q   <= 1'b0;
      out_vld_q <= 1'b0;
      beat_cnt  <= '0;
    end else begin
      state     <= state_nxt;
      ready_q   <= (state_nxt == IDLE) || (state_nxt == ACCUM);
      out_vld_q <= (state_nxt == HOLD);
      if (accept) beat_cnt <= last_beat ? '0 : beat_cnt + CNT_W'(1);
    end
  end

  // Stage 0: combinational lane products and their sum.
  always_comb begin
    lane_sum_p0 = '0;
    for (int i = 0; i < LANES; i++) begin
      lane_sum_p0 = lane_sum_p0 + mul_lane(bus.Wgt_bus[i*WGT_W +: WGT_W],
                                           bus.Pix_bus[i*PIX_W +: PIX_W]);
    end
  end

  // Stage 1: register the beat's lane sum; latch per-vector controls on the first beat.
  always_ff @(posedge clk or posedge GlobalReset) begin
    if (GlobalReset) begin
      sum_p1   <= '0;
      vld_p1   <= 1'b0;
      first_p1 <= 1'b0;
      last_p1  <= 1'b0;
      bias_q   <= '0;
      relu_q   <= 1'b0;
    end else begin
      vld_p1 <= accept;
      if (accept) begin
        sum_p1   <= lane_sum_p0;
        first_p1 <= first_beat;
        last_p1  <= last_beat;
      end
      if (accept && first_beat) begin
        bias_q <= bus.Bias;
        relu_q <= bus.Relu_en;
      end
    end
  end

  // Stage 2: accumulate; the first beat of a vector reloads from the bias.
  always_ff @(posedge clk or posedge GlobalReset) begin
    if (GlobalReset) begin
      acc_p2  <= '0;
      done_p2 <= 1'b0;
    end else begin
      done_p2 <= vld_p1 & last_p1;
      if (vld_p1) begin
        acc_p2 <= first_p1 ? (INT_W'(bias_q) + sum_p1) : (acc_p2 + sum_p1);
      end
    end
  end

  assign result_p2 = sat_fn(relu_fn(acc_p2, relu_q));

  // Output stage: capture once the last partial sum has landed; held until handshake.
  always_ff @(posedge clk or posedge GlobalReset) begin
    if (GlobalReset) begin
      out_q <= '0;
      sat_q <= 1'b0;
    end else if ((state == DRAIN) && done_p2) begin
      out_q <= signed'(result_p2[ACC_W-1:0]);
      sat_q <= result_p2[ACC_W];
    end
  end

  assign bus.Input_ready  = ready_q;
  assign bus.Output_valid = out_vld_q;
  assign bus.Out          = out_q;
  assign bus.Sat_flag     = sat_q;

endmodule

// File: tb/tb_neuron_mac_stream.sv
// Bench for neuron_mac_stream: table of vectors with scoreboard plus hold, reset and single-beat sequences.
module tb_neuron_mac_stream;
  localparam int N     = 64;
  localparam int L     = 16;
  localparam int WW    = 19;
  localparam int PW    = 10;
  localparam int AW    = 26;
  localparam int BEATS = N / L;
  localparam int NVEC  = 12;

  logic clk = 1'b0;
  logic GlobalReset;
  always #5 clk = ~clk;

  neuron_mac_stream_if #(.LANES(L),  .WGT_W(WW), .PIX_W(PW), .ACC_W(AW)) ifc ();
  neuron_mac_stream_if #(.LANES(64), .WGT_W(WW), .PIX_W(PW), .ACC_W(AW)) ifc1 ();

  neuron_mac_stream #(.N_INPUTS(N), .LANES(L), .WGT_W(WW), .PIX_W(PW), .ACC_W(AW)) dut (
    .clk(clk), .GlobalReset(GlobalReset), .bus(ifc));
  neuron_mac_stream #(.N_INPUTS(N), .LANES(64), .WGT_W(WW), .PIX_W(PW), .ACC_W(AW)) dut1 (
    .clk(clk), .GlobalReset(GlobalReset), .bus(ifc1));

  typedef struct {
    logic signed [WW-1:0] wgt;
    int                   pix;
    logic signed [AW-1:0] bias;
    logic                 relu;
    logic                 gaps;
    logic signed [AW-1:0] exp_out;
    logic                 exp_sat;
    string                name;
  } vec_t;

  typedef struct {
    logic signed [AW-1:0] out;
    logic                 sat;
  } exp_t;

  vec_t tbl [NVEC];
  exp_t sb_q [$];
  exp_t sb1_q [$];
  int   errors = 0;
  int   checks = 0;

  task automatic check(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input int w, input int pix, input int bias, input bit relu,
                              input bit gaps, input int exp_out, input bit exp_sat, input string nm);
    vec_t v;
    v.wgt = WW'(w); v.pix = pix; v.bias = AW'(bias); v.relu = relu; v.gaps = gaps;
    v.exp_out = AW'(exp_out); v.exp_sat = exp_sat; v.name = nm;
    return v;
  endfunction

  // pix < 0 selects the ramp pattern: lane i of beat b carries b*L+i.
  task automatic load_beat(input vec_t v, input int b);
    for (int i = 0; i < L; i++) begin
      ifc.Wgt_bus[i*WW +: WW] = v.wgt;
      ifc.Pix_bus[i*PW +: PW] = (v.pix < 0) ? PW'(b * L + i) : PW'(v.pix);
    end
    if (b == 0) begin
      ifc.Bias    = v.bias;
      ifc.Relu_en = v.relu;
    end else begin
      ifc.Bias    = AW'($urandom);
      ifc.Relu_en = ~v.relu;
    end
  endtask

  task automatic scramble_inputs();
    for (int i = 0; i < L; i++) begin
      ifc.Wgt_bus[i*WW +: WW] = WW'($urandom);
      ifc.Pix_bus[i*PW +: PW] = PW'($urandom);
    end
    ifc.Bias    = AW'($urandom);
    ifc.Relu_en = 1'($urandom);
  endtask

  task automatic send_vec(input vec_t v, input int nbeats, input bit push);
    for (int b = 0; b < nbeats; b++) begin
      bit got;
      int guard;
      load_beat(v, b);
      ifc.Input_valid = 1'b1;
      got = 1'b0;
      guard = 0;
      while (!got && guard < 50) begin
        @(negedge clk);
        got = ifc.Input_ready;
        @(posedge clk);
        #1;
        guard++;
      end
      ifc.Input_valid = 1'b0;
      scramble_inputs();
      if (!got) begin
        check({v.name, "_accept_timeout"}, 0, 1);
        return;
      end
      if (v.gaps && b < nbeats - 1) begin
        @(posedge clk);
        #1;
      end
    end
    if (push) sb_q.push_back('{v.exp_out, v.exp_sat});
  endtask

  task automatic collect(input string name, input bit do_ack);
    int   miss;
    exp_t e;
    miss = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (ifc.Output_valid) break;
      miss++;
    end
    if (!ifc.Output_valid) begin
      check({name, "_valid_timeout"}, 0, 1);
      return;
    end
    if (sb_q.size() == 0) begin
      check({name, "_sb_empty"}, 0, 1);
      return;
    end
    e = sb_q.pop_front();
    check({name, "_latency"}, miss, 2);
    check({name, "_out"}, ifc.Out, e.out);
    check({name, "_sat"}, ifc.Sat_flag, e.sat);
    if (do_ack) begin
      ifc.Output_ready = 1'b1;
      @(posedge clk);
      #1;
      ifc.Output_ready = 1'b0;
      check({name, "_valid_clr"}, ifc.Output_valid, 0);
      check({name, "_ready_up"}, ifc.Input_ready, 1);
      check({name, "_out_kept"}, ifc.Out, e.out);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    tbl[0]  = mk(1,       -1,    0,         0, 0, 2016,      0, "ramp_w1");
    tbl[1]  = mk(-1,      1023,  0,         0, 0, -65472,    0, "neg_w");
    tbl[2]  = mk(-1,      1023,  0,         1, 0, 0,         0, "neg_relu");
    tbl[3]  = mk(262143,  1023,  0,         0, 0, 33554431,  1, "sat_pos");
    tbl[4]  = mk(-262144, 1023,  0,         0, 0, -33554432, 1, "sat_neg");
    tbl[5]  = mk(-262144, 1023,  0,         1, 0, 0,         0, "sat_neg_relu");
    tbl[6]  = mk(1,       1,     10,        0, 0, 74,        0, "bias10");
    tbl[7]  = mk(1,       -1,    0,         0, 1, 2016,      0, "gaps");
    tbl[8]  = mk(3,       -1,    -5000,     1, 0, 1048,      0, "w3_relu_pos");
    tbl[9]  = mk(-2,      -1,    100,       0, 0, -3932,     0, "wm2_bias");
    tbl[10] = mk(1,       0,     33554431,  0, 0, 33554431,  0, "bias_max");
    tbl[11] = mk(-1,      1,     -33554432, 0, 0, -33554432, 1, "bias_min");

    GlobalReset       = 1'b1;
    ifc.Input_valid   = 1'b0;
    ifc.Wgt_bus       = '0;
    ifc.Pix_bus       = '0;
    ifc.Bias          = '0;
    ifc.Relu_en       = 1'b0;
    ifc.Output_ready  = 1'b0;
    ifc1.Input_valid  = 1'b0;
    ifc1.Wgt_bus      = '0;
    ifc1.Pix_bus      = '0;
    ifc1.Bias         = '0;
    ifc1.Relu_en      = 1'b0;
    ifc1.Output_ready = 1'b0;

    #3;
    check("rst_out", ifc.Out, 0);
    check("rst_valid", ifc.Output_valid, 0);
    check("rst_sat", ifc.Sat_flag, 0);
    check("rst_ready", ifc.Input_ready, 0);
    @(posedge clk);
    @(posedge clk);
    #1;
    GlobalReset = 1'b0;
    check("ready_before_edge", ifc.Input_ready, 0);
    @(posedge clk);
    #1;
    check("ready_after_edge", ifc.Input_ready, 1);

    for (int t = 0; t < NVEC; t++) begin
      send_vec(tbl[t], BEATS, 1'b1);
      collect(tbl[t].name, 1'b1);
    end

    // Back-pressure: result held for 5 cycles while extra beats are offered.
    send_vec(tbl[0], BEATS, 1'b1);
    collect("hold_first", 1'b0);
    for (int c = 0; c < 5; c++) begin
      scramble_inputs();
      ifc.Input_valid = 1'b1;
      @(posedge clk);
      #1;
      @(negedge clk);
      check("hold_out", ifc.Out, 2016);
      check("hold_valid", ifc.Output_valid, 1);
      check("hold_ready", ifc.Input_ready, 0);
    end
    ifc.Input_valid  = 1'b0;
    ifc.Output_ready = 1'b1;
    @(posedge clk);
    #1;
    ifc.Output_ready = 1'b0;
    check("hold_release_valid", ifc.Output_valid, 0);
    check("hold_release_ready", ifc.Input_ready, 1);
    send_vec(tbl[6], BEATS, 1'b1);
    collect("after_hold", 1'b1);

    // Reset after two beats of a vector.
    v = mk(1000, 1000, 12345, 0, 0, 0, 0, "partial");
    send_vec(v, 2, 1'b0);
    #2;
    GlobalReset = 1'b1;
    #1;
    check("midrst_out", ifc.Out, 0);
    check("midrst_valid", ifc.Output_valid, 0);
    check("midrst_sat", ifc.Sat_flag, 0);
    check("midrst_ready", ifc.Input_ready, 0);
    @(posedge clk);
    #1;
    GlobalReset = 1'b0;
    @(posedge clk);
    #1;
    v = mk(1, 1, 0, 0, 0, 64, 0, "post_reset");
    send_vec(v, BEATS, 1'b1);
    collect("post_reset", 1'b1);

    // Single-beat configuration.
    begin
      bit   got;
      int   miss;
      exp_t e;
      for (int i = 0; i < 64; i++) begin
        ifc1.Wgt_bus[i*WW +: WW] = WW'(1);
        ifc1.Pix_bus[i*PW +: PW] = PW'(i);
      end
      ifc1.Bias        = '0;
      ifc1.Relu_en     = 1'b0;
      ifc1.Input_valid = 1'b1;
      got = 1'b0;
      for (int k = 0; k < 20 && !got; k++) begin
        @(negedge clk);
        got = ifc1.Input_ready;
        @(posedge clk);
        #1;
      end
      ifc1.Input_valid = 1'b0;
      check("b1_accepted", got, 1);
      sb1_q.push_back('{AW'(2016), 1'b0});
      miss = 0;
      for (int k = 0; k < 20; k++) begin
        @(negedge clk);
        if (ifc1.Output_valid) break;
        miss++;
      end
      e = sb1_q.pop_front();
      check("b1_latency", miss, 2);
      check("b1_out", ifc1.Out, e.out);
      check("b1_sat", ifc1.Sat_flag, e.sat);
      ifc1.Output_ready = 1'b1;
      @(posedge clk);
      #1;
      ifc1.Output_ready = 1'b0;
      check("b1_valid_clr", ifc1.Output_valid, 0);
      check("b1_ready_up", ifc1.Input_ready, 1);
    end

    check("sb_drained", sb_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/neuron_mac_stream.md
NEURON_MAC_STREAM -- requirements
Module: neuron_mac_stream

Interface
REQ-001 SHALL have parameter N_INPUTS, default 64: weight/pixel pairs per vector.
REQ-002 SHALL have parameter LANES, default 16: pairs accepted per input beat.
REQ-003 SHALL have parameter WGT_W, default 19: weight width, signed two's complement.
REQ-004 SHALL have parameter PIX_W, default 10: pixel width, unsigned.
REQ-005 SHALL have parameter ACC_W, default 26: output width, signed.
REQ-006 SHALL have port clk, input, 1 bit: single clock; all state changes on the rising edge.
REQ-007 SHALL have port GlobalReset, input, 1 bit: reset, asynchronous, active-high.
REQ-008 SHALL have port Input_valid, input, 1 bit: the current beat is presented.
REQ-009 SHALL have port Input_ready, output, 1 bit: the block accepts a beat this cycle.
REQ-010 SHALL have port Wgt_bus, input, LANES*WGT_W bits: lane i at bits [i*WGT_W +: WGT_W].
REQ-011 SHALL have port Pix_bus, input, LANES*PIX_W bits: lane i at bits [i*PIX_W +: PIX_W].
REQ-012 SHALL have port Bias, input, ACC_W bits: signed bias added once per vector.
REQ-013 SHALL have port Relu_en, input, 1 bit: clamps a negative result to 0 when 1.
REQ-014 SHALL have port Out, output, ACC_W bits: signed result.
REQ-015 SHALL have port Output_valid, output, 1 bit: Out holds a complete result.
REQ-016 SHALL have port Output_ready, input, 1 bit: the consumer accepts Out.
REQ-017 SHALL have port Sat_flag, output, 1 bit: the current result was clamped to the ACC_W range.

Function
REQ-018 SHALL fail elaboration unless N_INPUTS mod LANES == 0; BEATS = N_INPUTS/LANES.
REQ-019 SHALL accept a beat only on an edge where Input_valid & Input_ready are both 1; a beat presented with Input_ready=0 is ignored.
REQ-020 SHALL implement states IDLE -> ACCUM (first beat accepted) -> DRAIN (last beat accepted) -> HOLD (result registered) -> IDLE (output handshake); if BEATS=1, the first beat moves IDLE directly to DRAIN.
REQ-021 SHALL drive Input_ready=1 in IDLE and ACCUM and 0 in DRAIN and HOLD.
REQ-022 SHALL count accepted beats with a ceil(log2(BEATS))-bit counter that clears when the last beat is accepted.
REQ-023 SHALL, on each accepting edge, register the stage-1 lane sum: the full-precision signed sum of LANES products, each product being signed weight times zero-extended pixel.
REQ-024 SHALL hold the accumulator at internal width INT_W = WGT_W+PIX_W+1+ceil(log2(N_INPUTS))+1, with no internal overflow.
REQ-025 SHALL load the accumulator with sign-extended Bias plus the stage-1 value of the vector's first beat, and add each later stage-1 value one cycle after its capture.
REQ-026 SHALL sample Relu_en and Bias on the first accepted beat and ignore their changes for the rest of the vector.
REQ-027 SHALL form the final result by applying ReLU first, then saturating to [-2^(ACC_W-1), 2^(ACC_W-1)-1].
REQ-028 SHALL set Sat_flag to 1 together with Output_valid when clamping occurs, and to 0 otherwise.
REQ-029 SHALL register Out and assert Output_valid on the 2nd rising edge after the edge that accepted the last beat.
REQ-030 SHALL hold Out, Sat_flag and Output_valid stable in HOLD while Output_ready=0.
REQ-031 SHALL, on an edge with Output_valid & Output_ready both 1, clear Output_valid, enter IDLE and raise Input_ready; Out retains its value.
REQ-032 SHALL treat Output_ready outside HOLD as having no effect.
REQ-033 SHALL accumulate correctly with idle cycles (Input_valid=0) between beats, keeping its state across the gaps.

Reset
REQ-034 SHALL, while GlobalReset=1, immediately force state IDLE, counter 0, accumulator 0, stage-1 0, Out 0, Output_valid 0, Sat_flag 0 and Input_ready 0.
REQ-035 SHALL drive Input_ready=1 from the first edge after GlobalReset deasserts.
REQ-036 SHALL, if reset is asserted mid-vector, discard the partial sum; the next vector SHALL be uncontaminated.

Verification
REQ-037 SHALL be verified (defaults): all weights 1, pixels 0..63 over 4 back-to-back beats, Bias=0, Relu_en=0 -> Out=2016 and Output_valid 2 edges after beat 4, Sat_flag=0.
REQ-038 SHALL be verified: all weights -1, pixels 1023 -> Out=-65472 with Relu_en=0; the same vector with Relu_en=1 -> Out=0.
REQ-039 SHALL be verified: all weights 262143, pixels 1023 -> Out=33554431, Sat_flag=1; all weights -262144, pixels 1023 -> Out=-33554432, Sat_flag=1.
REQ-040 SHALL be verified: hold Output_ready=0 for 5 cycles after Output_valid -> Out stable, Input_ready=0 and extra Input_valid beats ignored; after Output_ready=1 the next vector with weights 1, pixels 1, Bias=10 gives Out=74.
REQ-041 SHALL be verified: GlobalReset asserted after 2 beats -> all outputs 0; the next vector with weights 1, pixels 1 gives Out=64.
REQ-042 SHALL be verified: Input_valid toggling every cycle, vector from REQ-037 -> Out=2016; also LANES=64 (BEATS=1) -> Out=2016 two edges after the single beat.
